mop_issue_queue: RTL

- Sequential successor to the combinational micro-op cracker: buffers cracked micro-op bundles between decode and issue.
- Each cycle it accepts one macro-instruction bundle of 0..MAX_MOPS micro-ops, all-or-nothing, into a circular queue of DEPTH entries.
- Each cycle it presents up to ISSUE_W oldest micro-ops to the issue stage, tagged with macro-instruction boundary bits.
- Supports a pipeline flush (branch redirect) and reports occupancy for decode back-pressure.

---
 rtl/mop_issue_queue.sv | 117 +++++++++++
 1 files changed

// File: rtl/mop_issue_queue.sv
// Micro-op issue queue: a circular buffer between decode and issue.
// Takes one cracked macro-instruction bundle (0..MAX_MOPS micro-ops) per
// cycle, all-or-nothing, and presents up to ISSUE_W oldest micro-ops per
// cycle with a flag marking the final micro-op of each macro-instruction.
module mop_issue_queue #(
  parameter int MOP_W    = 128,
  parameter int MAX_MOPS = 6,
  parameter int DEPTH    = 16,
  parameter int ISSUE_W  = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  input  logic [$clog2(MAX_MOPS+1)-1:0]    in_cnt,
  input  logic [MAX_MOPS*MOP_W-1:0]        in_mops,
  output logic                             in_ready,
  output logic [$clog2(ISSUE_W+1)-1:0]     out_cnt,
  output logic [ISSUE_W*MOP_W-1:0]         out_mops,
  output logic [ISSUE_W-1:0]               out_last,
  input  logic [$clog2(ISSUE_W+1)-1:0]     out_take,
  input  logic                             flush,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             overflow_err
);

  localparam int IN_CNT_W  = $clog2(MAX_MOPS + 1);
  localparam int OUT_CNT_W = $clog2(ISSUE_W + 1);
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int PTR_W     = $clog2(DEPTH);

  // Each entry is {last_flag, micro_op}.
  logic [MOP_W:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow_err;

  logic               w_cnt_legal;
  logic               w_take_legal;
  logic [CNT_W-1:0]   w_free;
  logic               w_enq;
  logic               w_deq;
  logic [CNT_W-1:0]   w_enq_cnt;
  logic [CNT_W-1:0]   w_deq_cnt;

  // Admission is judged on registered occupancy only; slots freed by a
  // same-cycle dequeue are not counted, which keeps in_ready off the
  // issue-side timing path.
  assign w_cnt_legal  = (in_cnt <= IN_CNT_W'(MAX_MOPS));
  assign w_free       = CNT_W'(DEPTH) - r_count;
  assign in_ready     = w_cnt_legal && (w_free >= CNT_W'(in_cnt));

  // Taking more than is presented is illegal and the whole dequeue is dropped.
  assign w_take_legal = (out_take <= out_cnt);

  // Flush wins over both enqueue and dequeue.
  assign w_enq        = in_valid && in_ready && !flush;
  assign w_deq        = w_take_legal && !flush;
  assign w_enq_cnt    = w_enq ? CNT_W'(in_cnt) : '0;
  assign w_deq_cnt    = w_deq ? CNT_W'(out_take) : '0;

  assign out_cnt      = (r_count >= CNT_W'(ISSUE_W)) ? OUT_CNT_W'(ISSUE_W)
                                                     : OUT_CNT_W'(r_count);
  assign count        = r_count;
  assign overflow_err = r_overflow_err;

  // Pointer, occupancy and sticky error state.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_overflow_err <= 1'b0;
    end else begin
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + PTR_W'(w_deq_cnt);
        r_tail  <= r_tail + PTR_W'(w_enq_cnt);
        r_count <= r_count + w_enq_cnt - w_deq_cnt;
      end
      // Sticky until reset; a flush does not clear it.
      if ((in_valid && !w_cnt_legal) || !w_take_legal) begin
        r_overflow_err <= 1'b1;
      end
    end
  end

  // Write the accepted bundle at tail, wrapping, flagging its final micro-op.
  always_ff @(posedge clk) begin
    // NOTE: the entry array has no reset; contents are only ever read
    // behind a valid occupancy count, so clearing it would be wasted logic.
    for (int s = 0; s < MAX_MOPS; s++) begin
      if (w_enq && (s < int'(in_cnt))) begin
        r_mem[r_tail + PTR_W'(s)] <= {(s == int'(in_cnt) - 1),
                                      in_mops[s*MOP_W +: MOP_W]};
      end
    end
  end

  // Present the oldest ISSUE_W entries; last flags are masked beyond out_cnt.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path through
    // the block leaves a bit unassigned and infers a latch.
    out_mops = '0;
    out_last = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      out_mops[i*MOP_W +: MOP_W] = r_mem[r_head + PTR_W'(i)][MOP_W-1:0];
      out_last[i] = (i < int'(out_cnt)) && r_mem[r_head + PTR_W'(i)][MOP_W];
    end
  end

endmodule
